// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID skid stage.
//   state_t           : occupancy of the two-entry buffer
//   NOP_INSTR_DEFAULT : instruction shown to decode when nothing is held
//   DEF_INSTR_W/PC_W  : default field widths of a buffered entry
package if_id_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam int          DEF_INSTR_W       = 32;
    localparam int          DEF_PC_W          = 32;

endpackage

// File: rtl/if_id_skid_stage_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : add one this cycle
//   count : current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage built as a two-entry skid buffer (head + skid).
//   clk, rst_n            : clock and asynchronous active-low reset
//   in_valid/in_ready     : fetch-side handshake, in_instr/in_pc payload
//   stall                 : write-off, freezes contents and blocks both sides
//   flush                 : discards everything held plus any same-cycle input
//   out_valid/out_ready   : decode-side handshake, out_instr/out_pc = head
//   stall_cnt, flush_cnt  : saturating event counters
//
// state | meaning
// EMPTY | nothing held, outputs show NOP_INSTR / pc 0
// ONE   | head valid, skid free
// TWO   | head and skid valid, fetch back-pressured
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int          INSTR_W   = DEF_INSTR_W,
    parameter int          PC_W      = DEF_PC_W,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

    state_t state_q, state_nxt;
    entry_t head_q, head_nxt;
    entry_t skid_q, skid_nxt;
    entry_t in_entry;
    logic   push, pop;

    assign in_entry.instr = in_instr;
    assign in_entry.pc    = in_pc;

    // in_ready depends only on registered state and the local controls, never
    // on out_ready, so fetch sees no combinational path through decode.
    assign in_ready  = rst_n && !stall && !flush && (state_q != TWO);
    assign out_valid = (state_q != EMPTY) && !stall;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_instr = (state_q == EMPTY) ? NOP_W : head_q.instr;
    assign out_pc    = (state_q == EMPTY) ? '0    : head_q.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_nxt;
            head_q  <= head_nxt;
            skid_q  <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        head_nxt  = head_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            head_nxt  = '0;
            skid_nxt  = '0;
        end else if (!stall) begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        head_nxt  = in_entry;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt = TWO;
                        skid_nxt  = in_entry;
                    end else if (pop && !push) begin
                        state_nxt = EMPTY;
                    end else if (push && pop) begin
                        head_nxt  = in_entry;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt = ONE;
                        head_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Flush overrides stall, so a joint cycle only counts as a flush.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall && !flush),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc;
    logic [15:0] stall_cnt, flush_cnt;

    // second instance with narrow counters for saturation
    logic        s_stall;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_instr, s_out_pc;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_skid_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    if_id_skid_stage #(.CNT_W(2)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (1'b0),
        .in_ready  (s_in_ready),
        .in_instr  (32'h0),
        .in_pc     (32'h0),
        .stall     (s_stall),
        .flush     (1'b0),
        .out_valid (s_out_valid),
        .out_ready (1'b0),
        .out_instr (s_out_instr),
        .out_pc    (s_out_pc),
        .stall_cnt (s_stall_cnt),
        .flush_cnt (s_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b1; s_stall = 1'b0;
        repeat (5) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 00000000", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 00000000", out_pc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'd0, 32'd4, 32'd8};
        ins = '{32'h0F0F0F0F, 32'h0F0C0F0F, 32'h0C0F0F0F};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = pcs[i]; in_instr = ins[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== ins[i])
                begin errors++; $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", i, out_valid, out_pc, out_instr, pcs[i], ins[i]); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0)
            begin errors++; $display("FAIL stream_drain: got v=%b instr=%h expected v=0 instr=00000000", out_valid, out_instr); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'd0; in_instr = 32'hA000_0000;
        tick();
        in_pc = 32'd4; in_instr = 32'hA000_0004;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_second: got %b expected 1", in_ready); end
        tick();
        in_pc = 32'd8; in_instr = 32'hA000_0008;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_third: got %b expected 0", in_ready); end
        checks++; if (out_pc !== 32'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=00000000", out_valid, out_pc); end
        tick();
        checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL bp_head_held: got %h expected 00000000", out_pc); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'd4 || out_instr !== 32'hA000_0004) begin errors++; $display("FAIL bp_second_out: got pc=%h instr=%h expected pc=00000004 instr=a0000004", out_pc, out_instr); end
        tick();
        checks++; if (out_pc !== 32'd8 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third_out: got v=%b pc=%h expected v=1 pc=00000008", out_valid, out_pc); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'd4; in_instr = 32'hB000_0004;
        tick();
        in_pc = 32'd8; in_instr = 32'hB000_0008;
        tick();
        flush = 1'b1; in_pc = 32'd12; in_instr = 32'hB000_000C;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0)
            begin errors++; $display("FAIL flush_empty: got v=%b instr=%h pc=%h expected v=0 instr=00000000 pc=00000000", out_valid, out_instr, out_pc); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt: got %0d expected 1", flush_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_pc12: got v=%b pc=%h expected v=0", out_valid, out_pc); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'd12; in_instr = 32'h0000_3013;
        tick();
        stall = 1'b1; out_ready = 1'b1; in_pc = 32'd16; in_instr = 32'h0000_400F;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b0 || out_pc !== 32'd12 || in_ready !== 1'b0)
                begin errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h rdy=%b expected v=0 pc=0000000c rdy=0", i, out_valid, out_pc, in_ready); end
            tick();
        end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
        stall = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd12 || out_instr !== 32'h0000_3013)
            begin errors++; $display("FAIL stall_release_head: got v=%b pc=%h instr=%h expected v=1 pc=0000000c instr=00003013", out_valid, out_pc, out_instr); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd16 || out_instr !== 32'h0000_400F)
            begin errors++; $display("FAIL stall_next: got v=%b pc=%h instr=%h expected v=1 pc=00000010 instr=0000400f", out_valid, out_pc, out_instr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush_stall();
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        #1;
        checks++; if (flush_cnt !== 16'd2) begin errors++; $display("FAIL fs_flush_cnt: got %0d expected 2", flush_cnt); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL fs_stall_cnt: got %0d expected 3", stall_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        s_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (s_stall_cnt !== exp_cnt[i]) begin errors++; $display("FAIL sat_stall_cnt[%0d]: got %0d expected %0d", i, s_stall_cnt, exp_cnt[i]); end
        end
        s_stall = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'd20; in_instr = 32'hC000_0014;
        tick();
        in_pc = 32'd24; in_instr = 32'hC000_0018;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b0)
            begin errors++; $display("FAIL areset_outputs: got v=%b pc=%h rdy=%b expected v=0 pc=00000000 rdy=0", out_valid, out_pc, in_ready); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_stall_cnt !== 2'd0)
            begin errors++; $display("FAIL areset_counters: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, s_stall_cnt); end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'd28; in_instr = 32'hC000_001C;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd28 || out_instr !== 32'hC000_001C)
            begin errors++; $display("FAIL areset_first_out: got v=%b pc=%h instr=%h expected v=1 pc=0000001c instr=c000001c", out_valid, out_pc, out_instr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_drain: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall();
        test_flush_stall();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
